// File: rtl/reg_bank_drain.sv
// Eight-entry register bank with per-entry write enables; every freshly written
// entry is drained exactly once, round-robin, through a valid/ready read port.
module reg_bank_drain #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_in,
  input  logic [DEPTH-1:0] en,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic [2:0]       rd_idx,
  output logic [DEPTH-1:0] pending,
  output logic             overwrite
);
  localparam int IW = $clog2(DEPTH);

  // Read handshake: an update transfers on a rising clk edge where rd_valid and
  // rd_ready are both 1; rd_data/rd_idx hold steady while rd_valid=1 and
  // rd_ready=0, and rd_ready is ignored while rd_valid=0.
  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] dirty_q, dirty_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic [IW-1:0]    rd_idx_q, rd_idx_d;
  logic             overwrite_q, overwrite_d;

  logic [IW-1:0]    sel;
  logic [IW-1:0]    cand;
  logic             found;
  logic             load;
  logic [DEPTH-1:0] load_mask;

  // Scan from the far end back toward ptr so the nearest dirty entry wins.
  always_comb begin
    sel   = ptr_q;
    cand  = ptr_q;
    found = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      cand = ptr_q + IW'(k);
      if (dirty_q[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      ST_EMPTY: if (found) load = 1'b1;
      ST_FULL: begin
        if (rd_ready) begin
          if (found) load = 1'b1;
          else       state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (load) state_d = ST_FULL;
  end

  // A write landing on the entry being loaded keeps it dirty: the old value
  // leaves now and the new one drains on a later pass.
  always_comb begin
    load_mask   = '0;
    ptr_d       = ptr_q;
    rd_data_d   = rd_data_q;
    rd_idx_d    = rd_idx_q;
    if (load) begin
      load_mask[sel] = 1'b1;
      ptr_d          = sel + 1'b1;
      rd_data_d      = mem_q[sel];
      rd_idx_d       = sel;
    end
    dirty_d     = (dirty_q & ~load_mask) | en;
    overwrite_d = |(en & dirty_q & ~load_mask);
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = en[i] ? d_in : mem_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      dirty_q     <= '0;
      ptr_q       <= '0;
      rd_data_q   <= '0;
      rd_idx_q    <= '0;
      overwrite_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      dirty_q     <= dirty_d;
      ptr_q       <= ptr_d;
      rd_data_q   <= rd_data_d;
      rd_idx_q    <= rd_idx_d;
      overwrite_q <= overwrite_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign rd_valid  = (state_q == ST_FULL);
  assign rd_data   = rd_data_q;
  assign rd_idx    = 3'(rd_idx_q);
  assign pending   = dirty_q;
  assign overwrite = overwrite_q;
endmodule

// File: tb/tb_reg_bank_drain.sv
// Directed bench for reg_bank_drain: reset, single write, round-robin burst,
// backpressure with overwrite, write/load collision and reset mid-drain.
module tb_reg_bank_drain;
  logic       clk;
  logic       rst_n;
  logic [3:0] d_in;
  logic [7:0] en;
  logic       rd_valid;
  logic       rd_ready;
  logic [3:0] rd_data;
  logic [2:0] rd_idx;
  logic [7:0] pending;
  logic       overwrite;

  int n_checks = 0;
  int n_errors = 0;

  reg_bank_drain #(.WIDTH(4), .DEPTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .d_in      (d_in),
    .en        (en),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_idx    (rd_idx),
    .pending   (pending),
    .overwrite (overwrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [2:0] idx,
                         input logic [3:0] data);
    chk({tag, ".valid"}, 32'(rd_valid), 32'(v));
    chk({tag, ".idx"},   32'(rd_idx),   32'(idx));
    chk({tag, ".data"},  32'(rd_data),  32'(data));
  endtask

  initial begin
    rst_n = 1'b0; d_in = '0; en = '0; rd_ready = 1'b0;

    // Reset then idle
    tick(); tick();
    rst_n = 1'b1;
    chk_out("rst", 1'b0, 3'd0, 4'h0);
    chk("rst.pending", 32'(pending), 32'h0);
    chk("rst.overwrite", 32'(overwrite), 32'h0);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle.valid", 32'(rd_valid), 32'h0);
    end

    // Single write to entry 2
    d_in = 4'hA; en = 8'b0000_0100; rd_ready = 1'b1;
    tick();
    en = '0;
    chk("single.pending", 32'(pending), 32'h04);
    chk("single.valid_early", 32'(rd_valid), 32'h0);
    tick();
    chk_out("single.out", 1'b1, 3'd2, 4'hA);
    chk("single.pending_clr", 32'(pending), 32'h00);
    tick();
    chk("single.drained", 32'(rd_valid), 32'h0);

    // Re-reset so the pointer starts at 0, then write all eight entries
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    d_in = 4'h5; en = 8'hFF;
    tick();
    en = '0;
    chk("burst.pending", 32'(pending), 32'hFF);
    tick();
    for (int k = 0; k < 8; k++) begin
      chk_out($sformatf("burst%0d", k), 1'b1, 3'(k), 4'h5);
      tick();
    end
    chk("burst.end_valid", 32'(rd_valid), 32'h0);
    chk("burst.end_pending", 32'(pending), 32'h0);

    // Backpressure: entry 3 = 1, entry 5 = 2, consumer stalled
    rd_ready = 1'b0;
    d_in = 4'h1; en = 8'h08;
    tick();
    d_in = 4'h2; en = 8'h20;
    tick();
    en = '0;
    chk_out("bp.first", 1'b1, 3'd3, 4'h1);
    chk("bp.pending", 32'(pending), 32'h20);
    chk("bp.no_ovw", 32'(overwrite), 32'h0);
    tick();
    chk_out("bp.hold", 1'b1, 3'd3, 4'h1);
    d_in = 4'h7; en = 8'h20;
    tick();
    en = '0;
    chk("bp.ovw_pulse", 32'(overwrite), 32'h1);
    chk_out("bp.hold2", 1'b1, 3'd3, 4'h1);
    tick();
    chk("bp.ovw_drop", 32'(overwrite), 32'h0);
    chk_out("bp.hold3", 1'b1, 3'd3, 4'h1);
    rd_ready = 1'b1;
    tick();
    chk_out("bp.second", 1'b1, 3'd5, 4'h7);
    tick();
    chk("bp.end_valid", 32'(rd_valid), 32'h0);

    // Collision: entry 6 dirty with 4, rewritten to 9 on the edge it is loaded
    d_in = 4'h4; en = 8'h40;
    tick();
    chk("col.pending", 32'(pending), 32'h40);
    chk("col.valid0", 32'(rd_valid), 32'h0);
    d_in = 4'h9; en = 8'h40;
    tick();
    en = '0;
    chk_out("col.first", 1'b1, 3'd6, 4'h4);
    chk("col.still_dirty", 32'(pending), 32'h40);
    chk("col.no_ovw1", 32'(overwrite), 32'h0);
    tick();
    chk_out("col.second", 1'b1, 3'd6, 4'h9);
    chk("col.no_ovw2", 32'(overwrite), 32'h0);
    tick();
    chk("col.end_valid", 32'(rd_valid), 32'h0);

    // Reset mid-drain with pending = 8'h30
    rd_ready = 1'b0;
    d_in = 4'h3; en = 8'h02;
    tick();
    d_in = 4'h6; en = 8'h30;
    tick();
    en = '0;
    chk_out("mid.loaded", 1'b1, 3'd1, 4'h3);
    chk("mid.pending", 32'(pending), 32'h30);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_out("mid.rst", 1'b0, 3'd0, 4'h0);
    chk("mid.rst_pending", 32'(pending), 32'h0);
    d_in = 4'hB; en = 8'h81;
    tick();
    en = '0;
    tick();
    chk_out("mid.first", 1'b1, 3'd0, 4'hB);
    rd_ready = 1'b1;
    tick();
    chk_out("mid.second", 1'b1, 3'd7, 4'hB);
    tick();
    chk("mid.end_valid", 32'(rd_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
